// File: rtl/nn_layer_pkg.sv
// Shared definitions for the inter-layer activation interface:
// default activation width, streamer state encoding and the IEEE-754 zero test.
package nn_layer_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // +0 and -0 both count as zero; only the sign bit may be set.
  function automatic logic is_zero_f32(input logic [31:0] word);
    return ((word & 32'h7FFF_FFFF) == 32'd0);
  endfunction

endpackage

// File: rtl/next_set_bit.sv
// Priority encoder returning the lowest set mask bit at or above a start index.
// Only present in sparse builds (SKIP_ZERO_EN defined).
`ifdef SKIP_ZERO_EN
module next_set_bit #(
  parameter int N     = 30,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] pos,
  output logic             found
);

  // Scan downward so the lowest qualifying position is the one left standing.
  always_comb begin
    pos   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(start))) begin
        pos   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/layer_output_streamer.sv
// Captures a full layer of activations in one handshake and streams them one word per beat.
// Macro SKIP_ZERO_EN selects sparse mode, where zero-valued nodes are skipped.
module layer_output_streamer
  import nn_layer_pkg::state_t, nn_layer_pkg::ST_IDLE, nn_layer_pkg::ST_SEND;
#(
  parameter int N_NODES = 30,
  parameter int DATA_W  = nn_layer_pkg::DATA_W,
  parameter int IDX_W   = $clog2(N_NODES),
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      layer_valid,
  output logic                      layer_ready,
  input  logic [N_NODES*DATA_W-1:0] layer_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic [IDX_W-1:0]          m_index,
  output logic                      m_last,
  output logic                      busy,
  output logic [CNT_W-1:0]          frame_count
);

  state_t            state;
  logic [DATA_W-1:0] layer_words [N_NODES];
  logic [DATA_W-1:0] frame_buf   [N_NODES];
  logic              capture;
  logic [IDX_W-1:0]  first_idx;
  logic              first_last;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_last;

  for (genvar k = 0; k < N_NODES; k++) begin : g_unpack
    assign layer_words[k] = layer_data[k*DATA_W +: DATA_W];
  end

  assign capture = layer_valid && layer_ready;

`ifdef SKIP_ZERO_EN
  logic [N_NODES-1:0] mask_d;
  logic [N_NODES-1:0] mask_q;
  logic [N_NODES-1:0] enc_mask;
  logic [IDX_W-1:0]   enc_start;
  logic [IDX_W-1:0]   enc_pos;
  logic               enc_found;
  logic               hi_empty;

  for (genvar k = 0; k < N_NODES; k++) begin : g_mask
    assign mask_d[k] = !nn_layer_pkg::is_zero_f32(32'(layer_words[k]));
  end

  // One encoder serves both the first beat (live mask) and every advance (held mask).
  assign enc_mask  = (state == ST_IDLE) ? mask_d : mask_q;
  assign enc_start = (state == ST_IDLE) ? '0 : IDX_W'(m_index + 1'b1);

  next_set_bit #(
    .N     (N_NODES),
    .IDX_W (IDX_W)
  ) u_next_set_bit (
    .mask  (enc_mask),
    .start (enc_start),
    .pos   (enc_pos),
    .found (enc_found)
  );

  assign hi_empty = (((enc_mask >> enc_pos) >> 1) == '0);

  // An all-zero frame still emits one beat on the final node so the frame is not lost.
  assign first_idx  = enc_found ? enc_pos : IDX_W'(N_NODES - 1);
  assign first_last = enc_found ? hi_empty : 1'b1;
  assign sel_idx    = enc_pos;
  assign sel_last   = hi_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
    end else if (capture) begin
      mask_q <= mask_d;
    end
  end
`else
  assign first_idx  = '0;
  assign first_last = 1'b0;
  assign sel_idx    = IDX_W'(m_index + 1'b1);
  assign sel_last   = (sel_idx == IDX_W'(N_NODES - 1));
`endif

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < N_NODES; k++) begin
        frame_buf[k] <= layer_words[k];
      end
    end
  end

  // The first beat is taken straight from layer_data so it is valid one cycle after capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      layer_ready <= 1'b1;
      busy        <= 1'b0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
      m_index     <= '0;
      frame_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (capture) begin
            state       <= ST_SEND;
            layer_ready <= 1'b0;
            busy        <= 1'b1;
            m_valid     <= 1'b1;
            m_index     <= first_idx;
            m_data      <= layer_words[first_idx];
            m_last      <= first_last;
          end
        end
        ST_SEND: begin
          if (m_ready) begin
            if (m_last) begin
              state       <= ST_IDLE;
              layer_ready <= 1'b1;
              busy        <= 1'b0;
              m_valid     <= 1'b0;
              m_last      <= 1'b0;
              frame_count <= frame_count + 1'b1;
            end else begin
              m_index <= sel_idx;
              m_data  <= frame_buf[sel_idx];
              m_last  <= sel_last;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_output_streamer.sv
// Directed testbench for layer_output_streamer; sparse-mode scenarios run when SKIP_ZERO_EN is defined.
// A second, two-node instance with a 3-bit frame counter exercises counter wrap in few cycles.
module tb_layer_output_streamer;

  localparam int N   = 30;
  localparam int W   = 32;
  localparam int IW  = $clog2(N);
  localparam int SN  = 2;
  localparam int SCW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            layer_valid;
  logic            layer_ready;
  logic [N*W-1:0]  layer_data;
  logic            m_valid;
  logic            m_ready;
  logic [W-1:0]    m_data;
  logic [IW-1:0]   m_index;
  logic            m_last;
  logic            busy;
  logic [15:0]     frame_count;

  logic            s_layer_valid;
  logic            s_layer_ready;
  logic [SN*W-1:0] s_layer_data;
  logic            s_m_valid;
  logic            s_m_ready;
  logic [W-1:0]    s_m_data;
  logic [0:0]      s_m_index;
  logic            s_m_last;
  logic            s_busy;
  logic [SCW-1:0]  s_frame_count;

  int checks     = 0;
  int failures   = 0;
  int exp_frames = 0;

  logic [W+IW+1:0] got_beat;
  logic [W+IW+1:0] exp_beat;

  always #5 clk = ~clk;

  layer_output_streamer #(
    .N_NODES (N),
    .DATA_W  (W),
    .IDX_W   (IW),
    .CNT_W   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .layer_valid (layer_valid),
    .layer_ready (layer_ready),
    .layer_data  (layer_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_index     (m_index),
    .m_last      (m_last),
    .busy        (busy),
    .frame_count (frame_count)
  );

  layer_output_streamer #(
    .N_NODES (SN),
    .DATA_W  (W),
    .IDX_W   (1),
    .CNT_W   (SCW)
  ) dut_small (
    .clk         (clk),
    .rst         (rst),
    .layer_valid (s_layer_valid),
    .layer_ready (s_layer_ready),
    .layer_data  (s_layer_data),
    .m_valid     (s_m_valid),
    .m_ready     (s_m_ready),
    .m_data      (s_m_data),
    .m_index     (s_m_index),
    .m_last      (s_m_last),
    .busy        (s_busy),
    .frame_count (s_frame_count)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic [W-1:0] base);
    for (int k = 0; k < N; k++) layer_data[k*W +: W] = base + W'(k);
  endtask

  task automatic test_reset;
    rst = 1'b1; layer_valid = 1'b0; m_ready = 1'b0; layer_data = '0;
    s_layer_valid = 1'b0; s_m_ready = 1'b0; s_layer_data = '0;
    step; step;
    rst = 1'b0;
    checks++;
    if ({layer_ready, m_valid, busy, m_last} !== 4'b1000) begin
      failures++; $display("[TB] FAIL reset_flags: got=%b expected=1000", {layer_ready, m_valid, busy, m_last});
    end
    checks++;
    if ({m_data, m_index} !== '0) begin
      failures++; $display("[TB] FAIL reset_data_index: got=%h/%0d expected=0/0", m_data, m_index);
    end
    checks++;
    if (frame_count !== 16'd0 || s_frame_count !== 3'd0) begin
      failures++; $display("[TB] FAIL reset_frame_count: got=%0d/%0d expected=0/0", frame_count, s_frame_count);
    end
  endtask

  task automatic test_reset_mid_frame;
    set_frame(32'h4300_0000); layer_valid = 1'b1; m_ready = 1'b1;
    step;
    layer_valid = 1'b0;
    for (int b = 0; b <= 10; b++) begin
      checks++;
      if (m_valid !== 1'b1 || m_index !== IW'(b)) begin
        failures++; $display("[TB] FAIL midrst_beat%0d: got=v%b/i%0d expected=v1/i%0d", b, m_valid, m_index, b);
      end
      step;
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++;
    if ({m_valid, busy, layer_ready} !== 3'b001) begin
      failures++; $display("[TB] FAIL midrst_flags: got=%b expected=001", {m_valid, busy, layer_ready});
    end
    checks++;
    if (frame_count !== 16'(exp_frames)) begin
      failures++; $display("[TB] FAIL midrst_frame_count: got=%0d expected=%0d", frame_count, exp_frames);
    end
  endtask

  task automatic test_dense;
    set_frame(32'h3F80_0000); layer_valid = 1'b1; m_ready = 1'b1;
    step;
    layer_valid = 1'b0;
    for (int b = 0; b < N; b++) begin
      exp_beat = {1'b1, (b == N - 1), IW'(b), W'(32'h3F80_0000 + b)};
      got_beat = {m_valid, m_last, m_index, m_data};
      checks++;
      if (got_beat !== exp_beat) begin
        failures++; $display("[TB] FAIL dense_beat%0d: got=%h expected=%h", b, got_beat, exp_beat);
      end
      step;
    end
    exp_frames++;
    checks++;
    if ({m_valid, busy, layer_ready} !== 3'b001) begin
      failures++; $display("[TB] FAIL dense_end_flags: got=%b expected=001", {m_valid, busy, layer_ready});
    end
    checks++;
    if (frame_count !== 16'(exp_frames)) begin
      failures++; $display("[TB] FAIL dense_frame_count: got=%0d expected=%0d", frame_count, exp_frames);
    end
  endtask

  task automatic test_stall;
    int   exp_idx;
    int   cyc;
    logic stalled;
    logic [W+IW+1:0] held;
    set_frame(32'h4000_0100); layer_valid = 1'b1; m_ready = 1'b0;
    step;
    layer_valid = 1'b0;
    exp_idx = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (exp_idx < N && cyc < 400) begin
      got_beat = {m_valid, m_last, m_index, m_data};
      if (stalled) begin
        checks++;
        if (got_beat !== held) begin
          failures++; $display("[TB] FAIL stall_hold_cyc%0d: got=%h expected=%h", cyc, got_beat, held);
        end
      end
      m_ready = 1'($urandom_range(0, 1));
      if (m_ready) begin
        exp_beat = {1'b1, (exp_idx == N - 1), IW'(exp_idx), W'(32'h4000_0100 + exp_idx)};
        checks++;
        if (got_beat !== exp_beat) begin
          failures++; $display("[TB] FAIL stall_beat%0d: got=%h expected=%h", exp_idx, got_beat, exp_beat);
        end
        exp_idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = {1'b1, (exp_idx == N - 1), IW'(exp_idx), W'(32'h4000_0100 + exp_idx)};
      end
      step;
      cyc++;
    end
    m_ready = 1'b1;
    checks++;
    if (exp_idx != N) begin
      failures++; $display("[TB] FAIL stall_timeout: got=%0d beats expected=%0d", exp_idx, N);
    end
    exp_frames++;
    checks++;
    if (m_valid !== 1'b0 || frame_count !== 16'(exp_frames)) begin
      failures++; $display("[TB] FAIL stall_end: got=v%b/fc%0d expected=v0/fc%0d", m_valid, frame_count, exp_frames);
    end
  endtask

  task automatic test_hold_valid;
    set_frame(32'h4100_0000); layer_valid = 1'b1; m_ready = 1'b1;
    step;
    for (int b = 0; b < N; b++) begin
      set_frame(32'h4200_0000 + (b << 8));
      exp_beat = {1'b1, (b == N - 1), IW'(b), W'(32'h4100_0000 + b)};
      got_beat = {m_valid, m_last, m_index, m_data};
      checks++;
      if (got_beat !== exp_beat || layer_ready !== 1'b0) begin
        failures++; $display("[TB] FAIL hold_beat%0d: got=%h/r%b expected=%h/r0", b, got_beat, layer_ready, exp_beat);
      end
      step;
    end
    exp_frames++;
    checks++;
    if ({m_valid, layer_ready} !== 2'b01 || frame_count !== 16'(exp_frames)) begin
      failures++; $display("[TB] FAIL hold_gap: got=v%b/r%b/fc%0d expected=v0/r1/fc%0d", m_valid, layer_ready, frame_count, exp_frames);
    end
    set_frame(32'h4400_0000);
    step;
    layer_valid = 1'b0;
    checks++;
    if ({m_valid, m_index, m_data} !== {1'b1, IW'(0), 32'h4400_0000}) begin
      failures++; $display("[TB] FAIL hold_second_capture: got=v%b/i%0d/%h expected=v1/i0/44000000", m_valid, m_index, m_data);
    end
    for (int c = 0; c < 40 && m_valid; c++) step;
    exp_frames++;
    checks++;
    if (m_valid !== 1'b0 || frame_count !== 16'(exp_frames)) begin
      failures++; $display("[TB] FAIL hold_second_end: got=v%b/fc%0d expected=v0/fc%0d", m_valid, frame_count, exp_frames);
    end
  endtask

`ifdef SKIP_ZERO_EN
  task automatic test_sparse;
    layer_data = '0;
    layer_data[3*W +: W] = 32'h3F80_0003;
    layer_data[5*W +: W] = 32'h8000_0000;
    layer_data[7*W +: W] = 32'hBF80_0007;
    layer_valid = 1'b1; m_ready = 1'b1;
    step;
    layer_valid = 1'b0;
    exp_beat = {1'b1, 1'b0, IW'(3), 32'h3F80_0003};
    got_beat = {m_valid, m_last, m_index, m_data};
    checks++;
    if (got_beat !== exp_beat) begin
      failures++; $display("[TB] FAIL sparse_beat_a: got=%h expected=%h", got_beat, exp_beat);
    end
    step;
    exp_beat = {1'b1, 1'b1, IW'(7), 32'hBF80_0007};
    got_beat = {m_valid, m_last, m_index, m_data};
    checks++;
    if (got_beat !== exp_beat) begin
      failures++; $display("[TB] FAIL sparse_beat_b: got=%h expected=%h", got_beat, exp_beat);
    end
    step;
    exp_frames++;
    checks++;
    if (m_valid !== 1'b0 || frame_count !== 16'(exp_frames)) begin
      failures++; $display("[TB] FAIL sparse_end: got=v%b/fc%0d expected=v0/fc%0d", m_valid, frame_count, exp_frames);
    end
    layer_data = '0; layer_valid = 1'b1;
    step;
    layer_valid = 1'b0;
    exp_beat = {1'b1, 1'b1, IW'(N - 1), 32'h0000_0000};
    got_beat = {m_valid, m_last, m_index, m_data};
    checks++;
    if (got_beat !== exp_beat) begin
      failures++; $display("[TB] FAIL sparse_all_zero: got=%h expected=%h", got_beat, exp_beat);
    end
    step;
    exp_frames++;
    checks++;
    if (m_valid !== 1'b0 || frame_count !== 16'(exp_frames)) begin
      failures++; $display("[TB] FAIL sparse_zero_end: got=v%b/fc%0d expected=v0/fc%0d", m_valid, frame_count, exp_frames);
    end
  endtask
`endif

  task automatic test_frame_count_wrap;
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    s_m_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      w0 = 32'h3F80_0000 + 32'(2 * f);
      w1 = 32'h3F80_0000 + 32'(2 * f + 1);
      s_layer_data = {w1, w0};
      s_layer_valid = 1'b1;
      step;
      s_layer_valid = 1'b0;
      checks++;
      if ({s_m_valid, s_m_last, s_m_index, s_m_data} !== {1'b1, 1'b0, 1'b0, w0}) begin
        failures++; $display("[TB] FAIL wrap_beat0_f%0d: got=v%b/l%b/i%0d/%h expected=v1/l0/i0/%h", f, s_m_valid, s_m_last, s_m_index, s_m_data, w0);
      end
      step;
      checks++;
      if ({s_m_valid, s_m_last, s_m_index, s_m_data} !== {1'b1, 1'b1, 1'b1, w1}) begin
        failures++; $display("[TB] FAIL wrap_beat1_f%0d: got=v%b/l%b/i%0d/%h expected=v1/l1/i1/%h", f, s_m_valid, s_m_last, s_m_index, s_m_data, w1);
      end
      step;
      checks++;
      if (s_frame_count !== SCW'((f + 1) % 8)) begin
        failures++; $display("[TB] FAIL wrap_count_f%0d: got=%0d expected=%0d", f, s_frame_count, (f + 1) % 8);
      end
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_frame;
    test_dense;
    test_stall;
    test_hold_valid;
`ifdef SKIP_ZERO_EN
    test_sparse;
`endif
    test_frame_count_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish in time");
  end

endmodule
